// File: rtl/cacheline_adaptor.sv
// Bridges a 256-bit line request to a 4-beat 64-bit memory burst; resp_o follows the 4th beat by one cycle.
// Gaps on resp_i stall the burst indefinitely; CACHELINE_ADAPTOR_CWF_EN selects critical-word-first beat order.
module cacheline_adaptor (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [255:0] line_i,
    output logic [255:0] line_o,
    input  logic [31:0]  address_i,
    input  logic         read_i,
    input  logic         write_i,
    output logic         resp_o,
    input  logic [63:0]  burst_i,
    output logic [63:0]  burst_o,
    output logic [31:0]  address_o,
    output logic         read_o,
    output logic         write_o,
    input  logic         resp_i
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_BURST = 2'd1,
        WR_BURST = 2'd2,
        DONE     = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [1:0]     slot_q, slot_d;
    logic [1:0]     nbeat_q, nbeat_d;
    logic [31:0]    addr_q, addr_d;
    logic [255:0]   wline_q, wline_d;
    logic [255:0]   rline_q, rline_d;
    logic [1:0]     start_slot;
    logic           last_beat;
    logic           unused_addr;

    // Slot order and beat count are tracked separately so a wrapped CWF burst still ends after 4 beats.
`ifdef CACHELINE_ADAPTOR_CWF_EN
    assign start_slot = address_i[4:3];
`else
    assign start_slot = 2'b00;
`endif

    assign unused_addr = ^address_i[4:0];
    assign last_beat   = resp_i && (nbeat_q == 2'd3);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (write_i) begin
                    state_d = WR_BURST;
                end else if (read_i) begin
                    state_d = RD_BURST;
                end
            end
            RD_BURST: begin
                if (last_beat) begin
                    state_d = DONE;
                end
            end
            WR_BURST: begin
                if (last_beat) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        read_o    = (state_q == RD_BURST) && (nbeat_q == 2'd0);
        write_o   = (state_q == WR_BURST);
        resp_o    = (state_q == DONE);
        burst_o   = '0;
        address_o = addr_q;
        line_o    = rline_q;
        if (state_q == WR_BURST) begin
            burst_o = wline_q[{slot_q, 6'b0} +: 64];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            slot_q  <= 2'd0;
            nbeat_q <= 2'd0;
            addr_q  <= '0;
            wline_q <= '0;
            rline_q <= '0;
        end else begin
            slot_q  <= slot_d;
            nbeat_q <= nbeat_d;
            addr_q  <= addr_d;
            wline_q <= wline_d;
            rline_q <= rline_d;
        end
    end

    always_comb begin
        slot_d  = slot_q;
        nbeat_d = nbeat_q;
        addr_d  = addr_q;
        wline_d = wline_q;
        rline_d = rline_q;
        case (state_q)
            IDLE: begin
                if (write_i || read_i) begin
                    addr_d  = {address_i[31:5], start_slot, 3'b000};
                    slot_d  = start_slot;
                    nbeat_d = 2'd0;
                    if (write_i) begin
                        wline_d = line_i;
                    end
                end
            end
            RD_BURST: begin
                if (resp_i) begin
                    rline_d[{slot_q, 6'b0} +: 64] = burst_i;
                    slot_d  = slot_q + 2'd1;
                    nbeat_d = nbeat_q + 2'd1;
                end
            end
            WR_BURST: begin
                if (resp_i) begin
                    slot_d  = slot_q + 2'd1;
                    nbeat_d = nbeat_q + 2'd1;
                end
            end
            default: begin
            end
        endcase
    end

endmodule
